// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: processor (p) and external (x) share one memory with 1-cycle responses.
// Define DMEM_ARBITER_STARVE_GUARD_EN to let a starved x request override processor priority.
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p_req_val,
  input  logic        p_req_type,
  input  logic [31:0] p_req_addr,
  input  logic [31:0] p_req_wdata,
  output logic        p_req_rdy,
  output logic        p_resp_val,
  output logic [31:0] p_resp_rdata,
  input  logic        x_req_val,
  input  logic        x_req_type,
  input  logic [31:0] x_req_addr,
  input  logic [31:0] x_req_wdata,
  output logic        x_req_rdy,
  output logic        x_resp_val,
  output logic [31:0] x_resp_rdata,
  output logic        mem_req_val,
  output logic        mem_req_type,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  input  logic [31:0] mem_resp_rdata
);
  typedef enum logic [1:0] {IDLE, RESP_P, RESP_X} owner_t;

  owner_t      r_owner, w_owner_nxt;
  logic [31:0] r_rdata;
  logic        w_x_first, w_p_gnt, w_x_gnt;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_limit
    $error("dmem_arbiter: STARVE_LIMIT must be 1..7");
  end

`ifdef DMEM_ARBITER_STARVE_GUARD_EN
  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);
  logic [2:0] r_wait_cnt;

  assign w_x_first = x_req_val && (r_wait_cnt == LIMIT);

  // Counts cycles x was waiting but lost; saturates so the override stays armed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  r_wait_cnt <= '0;
    else if (w_x_gnt)                         r_wait_cnt <= '0;
    else if (x_req_val && r_wait_cnt != LIMIT) r_wait_cnt <= r_wait_cnt + 3'd1;
  end
`else
  assign w_x_first = 1'b0;
`endif

  assign w_p_gnt   = !rst && p_req_val && !w_x_first;
  assign w_x_gnt   = !rst && x_req_val && !w_p_gnt;
  assign p_req_rdy = w_p_gnt;
  assign x_req_rdy = w_x_gnt;

  always_comb begin
    mem_req_val   = 1'b0;
    mem_req_type  = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    if (w_p_gnt) begin
      mem_req_val   = 1'b1;
      mem_req_type  = p_req_type;
      mem_req_addr  = p_req_addr;
      mem_req_wdata = p_req_wdata;
    end else if (w_x_gnt) begin
      mem_req_val   = 1'b1;
      mem_req_type  = x_req_type;
      mem_req_addr  = x_req_addr;
      mem_req_wdata = x_req_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_owner <= IDLE;
    else     r_owner <= w_owner_nxt;
  end

  always_comb begin
    w_owner_nxt = IDLE;
    if (w_p_gnt)      w_owner_nxt = RESP_P;
    else if (w_x_gnt) w_owner_nxt = RESP_X;
  end

  // Writes return zero data, so the mux happens before the register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_rdata <= '0;
    else if (mem_req_val) r_rdata <= mem_req_type ? 32'd0 : mem_resp_rdata;
    else                  r_rdata <= '0;
  end

  assign p_resp_val   = (r_owner == RESP_P);
  assign x_resp_val   = (r_owner == RESP_X);
  assign p_resp_rdata = p_resp_val ? r_rdata : 32'd0;
  assign x_resp_rdata = x_resp_val ? r_rdata : 32'd0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle reference model plus hand-computed literal checks.
module tb_dmem_arbiter;
`ifdef DMEM_ARBITER_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam int LIMIT = 3;

  logic        clk = 1'b0, rst = 1'b1;
  logic        p_req_val = 0, p_req_type = 0, x_req_val = 0, x_req_type = 0;
  logic [31:0] p_req_addr = 0, p_req_wdata = 0, x_req_addr = 0, x_req_wdata = 0;
  logic        p_req_rdy, p_resp_val, x_req_rdy, x_resp_val;
  logic [31:0] p_resp_rdata, x_resp_rdata;
  logic        mem_req_val, mem_req_type;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_rdata;

  logic [31:0] tb_mem [256];
  logic [31:0] mmem   [256];
  int          n_chk = 0, n_fail = 0;
  int          m_owner = 0, m_cnt = 0;
  logic [31:0] m_rdata = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .p_req_val(p_req_val), .p_req_type(p_req_type), .p_req_addr(p_req_addr),
    .p_req_wdata(p_req_wdata), .p_req_rdy(p_req_rdy), .p_resp_val(p_resp_val),
    .p_resp_rdata(p_resp_rdata),
    .x_req_val(x_req_val), .x_req_type(x_req_type), .x_req_addr(x_req_addr),
    .x_req_wdata(x_req_wdata), .x_req_rdy(x_req_rdy), .x_resp_val(x_resp_val),
    .x_resp_rdata(x_resp_rdata),
    .mem_req_val(mem_req_val), .mem_req_type(mem_req_type), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_resp_rdata(mem_resp_rdata)
  );

  // Environment memory: combinational read, write on the clock edge.
  assign mem_resp_rdata = tb_mem[mem_req_addr[9:2]];
  always @(posedge clk)
    if (!rst && mem_req_val && mem_req_type) tb_mem[mem_req_addr[9:2]] <= mem_req_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: decides this cycle's winner from the priority rules and
  // predicts next cycle's response from its own copy of memory.
  always @(negedge clk) begin
    logic e_p, e_x, x_first, e_type;
    logic [31:0] e_addr, e_wdata;
    if (rst) begin
      chk("rst p_rdy", 32'(p_req_rdy), 0);
      chk("rst x_rdy", 32'(x_req_rdy), 0);
      chk("rst mem_val", 32'(mem_req_val), 0);
      chk("rst p_resp_val", 32'(p_resp_val), 0);
      chk("rst x_resp_val", 32'(x_resp_val), 0);
      m_owner = 0; m_cnt = 0; m_rdata = 0;
    end else begin
      chk("p_resp_val", 32'(p_resp_val), 32'(m_owner == 1));
      chk("x_resp_val", 32'(x_resp_val), 32'(m_owner == 2));
      chk("p_resp_rdata", p_resp_rdata, (m_owner == 1) ? m_rdata : 32'd0);
      chk("x_resp_rdata", x_resp_rdata, (m_owner == 2) ? m_rdata : 32'd0);
      x_first = GUARD && x_req_val && (m_cnt >= LIMIT);
      e_p = p_req_val && !x_first;
      e_x = x_req_val && !e_p;
      e_type  = e_p ? p_req_type  : e_x ? x_req_type  : 1'b0;
      e_addr  = e_p ? p_req_addr  : e_x ? x_req_addr  : 32'd0;
      e_wdata = e_p ? p_req_wdata : e_x ? x_req_wdata : 32'd0;
      chk("p_rdy", 32'(p_req_rdy), 32'(e_p));
      chk("x_rdy", 32'(x_req_rdy), 32'(e_x));
      chk("mem_val", 32'(mem_req_val), 32'(e_p || e_x));
      chk("mem_type", 32'(mem_req_type), 32'(e_type));
      chk("mem_addr", mem_req_addr, e_addr);
      chk("mem_wdata", mem_req_wdata, e_wdata);
      m_owner = e_p ? 1 : e_x ? 2 : 0;
      m_rdata = 0;
      if (e_p || e_x) begin
        if (e_type) mmem[e_addr[9:2]] = e_wdata;
        else        m_rdata = mmem[e_addr[9:2]];
      end
      if (e_x)                           m_cnt = 0;
      else if (x_req_val && m_cnt < LIMIT) m_cnt++;
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic mid();  @(negedge clk); #1; endtask
  task automatic drive(input logic pv, input logic pt, input logic [31:0] pa, input logic [31:0] pw,
                       input logic xv, input logic xt, input logic [31:0] xa, input logic [31:0] xw);
    p_req_val = pv; p_req_type = pt; p_req_addr = pa; p_req_wdata = pw;
    x_req_val = xv; x_req_type = xt; x_req_addr = xa; x_req_wdata = xw;
  endtask
  task automatic idle(); drive(0, 0, 0, 0, 0, 0, 0, 0); endtask

  typedef struct packed {
    logic pv, pt; logic [31:0] pa, pw;
    logic xv, xt; logic [31:0] xa, xw;
  } vec_t;
  vec_t vecs [8];

  initial begin
    for (int i = 0; i < 256; i++) begin
      tb_mem[i] = 32'hA500_0000 | 32'(i);
      mmem[i]   = 32'hA500_0000 | 32'(i);
    end
    tb_mem[64] = 32'hDEADBEEF; mmem[64] = 32'hDEADBEEF;
    tb_mem[65] = 32'hCAFEF00D; mmem[65] = 32'hCAFEF00D;

    // Requests during reset must not be granted.
    drive(1, 0, 32'h100, 0, 1, 0, 32'h104, 0);
    tick(); tick();

    // Single read, granted in the first cycle out of reset.
    rst = 1'b0;
    drive(1, 0, 32'h100, 0, 0, 0, 0, 0);
    mid(); chk("single p_rdy", 32'(p_req_rdy), 1);
    tick(); idle();
    mid();
    chk("single p_resp_val", 32'(p_resp_val), 1);
    chk("single p_rdata", p_resp_rdata, 32'hDEADBEEF);
    chk("single x_resp_val", 32'(x_resp_val), 0);

    // Idle for 10 cycles.
    for (int c = 0; c < 10; c++) begin
      tick(); mid();
      chk("idle mem_val", 32'(mem_req_val), 0);
      chk("idle resp_val", 32'({p_resp_val, x_resp_val}), 0);
`ifdef DMEM_ARBITER_STARVE_GUARD_EN
      chk("idle cnt", 32'(dut.r_wait_cnt), 0);
`endif
    end

    // Both ports continuously valid for 5 cycles.
    tick(); drive(1, 0, 32'h100, 0, 1, 0, 32'h104, 0);
    for (int c = 0; c < 5; c++) begin
      mid();
      if (GUARD) begin
        chk("starve p_rdy", 32'(p_req_rdy), 32'(c != 3));
        chk("starve x_rdy", 32'(x_req_rdy), 32'(c == 3));
      end else begin
        chk("strict p_rdy", 32'(p_req_rdy), 1);
        chk("strict x_rdy", 32'(x_req_rdy), 0);
      end
`ifdef DMEM_ARBITER_STARVE_GUARD_EN
      if (c == 4) chk("starve cnt cleared", 32'(dut.r_wait_cnt), 0);
`endif
      tick();
    end
    idle();
    tick();
`ifdef DMEM_ARBITER_STARVE_GUARD_EN
    // One more reset to start the next tests from a zero counter.
    rst = 1'b1; tick(); rst = 1'b0;
`endif

    // Alternating owners: x write then p read of the same word.
    drive(0, 0, 0, 0, 1, 1, 32'h20, 32'h55);
    tick(); drive(1, 0, 32'h20, 0, 0, 0, 0, 0);
    mid();
    chk("alt x_resp_val", 32'(x_resp_val), 1);
    chk("alt x_rdata", x_resp_rdata, 0);
    tick(); idle();
    mid();
    chk("alt p_resp_val", 32'(p_resp_val), 1);
    chk("alt p_rdata", p_resp_rdata, 32'h55);

    // Back-to-back mix, held requests when not granted.
    vecs[0] = '{1, 1, 32'h40, 32'h11111111, 0, 0, 0, 0};
    vecs[1] = '{0, 0, 0, 0, 1, 1, 32'h44, 32'h22222222};
    vecs[2] = '{1, 0, 32'h44, 0, 1, 0, 32'h40, 0};
    vecs[3] = '{0, 0, 0, 0, 1, 0, 32'h40, 0};
    vecs[4] = '{1, 0, 32'h40, 0, 1, 1, 32'h48, 32'h33};
    vecs[5] = '{1, 1, 32'h4C, 32'hAB, 1, 1, 32'h48, 32'h33};
    vecs[6] = '{0, 0, 0, 0, 1, 1, 32'h48, 32'h33};
    vecs[7] = '{1, 0, 32'h48, 0, 1, 0, 32'h4C, 0};
    tick();
    for (int v = 0; v < 8; v++) begin
      drive(vecs[v].pv, vecs[v].pt, vecs[v].pa, vecs[v].pw,
            vecs[v].xv, vecs[v].xt, vecs[v].xa, vecs[v].xw);
      tick();
    end
    idle();
    tick(); tick();

    // Reset arriving while a response is being presented.
    drive(1, 0, 32'h100, 0, 0, 0, 0, 0);
    tick(); idle();
    chk("pre-rst p_resp_val", 32'(p_resp_val), 1);
    #1 rst = 1'b1;
    #1 chk("rst drops p_resp_val", 32'(p_resp_val), 0);
    tick(); rst = 1'b0;
    mid();
    chk("post-rst p_resp_val", 32'(p_resp_val), 0);
    chk("post-rst x_resp_val", 32'(x_resp_val), 0);
`ifdef DMEM_ARBITER_STARVE_GUARD_EN
    chk("post-rst cnt", 32'(dut.r_wait_cnt), 0);
`endif
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
